// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: operation
// encodings and the elaboration-time configuration check.
package addsub_pkg;

   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

   // True when the operand width splits into whole, non-empty slices.
   function automatic bit chunk_cfg_ok(input int width, input int chunk);
      if (chunk < 1) return 1'b0;
      return (width % chunk) == 0;
   endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry slice; one instance per pipeline stage.
// c_msb exposes the carry into the slice's top bit for signed overflow.
module addsub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   logic [CHUNK:0] carry;

   // Ripple the carry bit by bit through the slice.
   always_comb begin
      carry    = '0;
      s        = '0;
      carry[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         s[i]       = x[i] ^ y[i] ^ carry[i];
         carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
      end
      cout  = carry[CHUNK];
      c_msb = carry[CHUNK-1];
   end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/subtract. Each stage adds one CHUNK-bit
// slice and carries the remaining operand bits forward; per-stage valid
// bits with a ready chain let empty stages fill while the output stalls.
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   z,
   output logic             ovf
);

   localparam int STAGES = WIDTH / CHUNK;

   if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
      $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
   end

   // Stage registers
   logic [STAGES-1:0] v_q;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [STAGES-1:0] c_q;
   logic              m_q;

   // Stage inputs (from the port for stage 0, previous stage otherwise)
   logic [WIDTH-1:0]  a_src [STAGES];
   logic [WIDTH-1:0]  b_src [STAGES];
   logic [WIDTH-1:0]  s_src [STAGES];
   logic [STAGES-1:0] c_src;
   logic [STAGES-1:0] v_src;

   logic [WIDTH-1:0]  s_d   [STAGES];
   logic [CHUNK-1:0]  sum_c [STAGES];
   logic              co_c  [STAGES];
   logic              cm_c  [STAGES];
   logic [STAGES:0]   rdy;
   logic [STAGES-1:0] ld;

   // Select each stage's operands: b is inverted and sub becomes carry-in.
   always_comb begin
      c_src    = '0;
      v_src    = '0;
      a_src[0] = a;
      b_src[0] = (sub == SUB) ? ~b : b;
      s_src[0] = '0;
      c_src[0] = (sub == SUB);
      v_src[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         a_src[k] = a_q[k-1];
         b_src[k] = b_q[k-1];
         s_src[k] = s_q[k-1];
         c_src[k] = c_q[k-1];
         v_src[k] = v_q[k-1];
      end
   end

   // Ready chain from the consumer back to the input; an empty stage is always ready.
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         rdy[k] = !v_q[k] || rdy[k+1];
      end
   end

   assign ld = rdy[STAGES-1:0] & v_src;

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
         .x     (a_src[g][g*CHUNK +: CHUNK]),
         .y     (b_src[g][g*CHUNK +: CHUNK]),
         .cin   (c_src[g]),
         .s     (sum_c[g]),
         .cout  (co_c[g]),
         .c_msb (cm_c[g])
      );
   end

   // Merge each stage's new sum slice into the partial sum it received.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         s_d[k] = s_src[k];
         s_d[k][k*CHUNK +: CHUNK] = sum_c[k];
      end
   end

   // Stage valid bits advance whenever the stage's downstream can take data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) v_q[k] <= v_src[k];
         end
      end
   end

   // Stage data loads only with a valid beat, so stalled results hold steady.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
         c_q <= '0;
         m_q <= 1'b0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) begin
               a_q[k] <= a_src[k];
               b_q[k] <= b_src[k];
               s_q[k] <= s_d[k];
               c_q[k] <= co_c[k];
            end
         end
         if (ld[STAGES-1]) m_q <= cm_c[STAGES-1];
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = v_q[STAGES-1];
   assign z         = {c_q[STAGES-1], s_q[STAGES-1]};
   assign ovf       = c_q[STAGES-1] ^ m_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed cases, a stalled random stream and a
// reset flush on a 16/4 instance, plus a single-stage 8/8 instance.
module tb_pipelined_addsub;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        v16, ir16, s16, ov16, r16, of16;
   logic [15:0] a16, b16;
   logic [16:0] z16;

   logic        v8, ir8, s8, ov8, r8, of8;
   logic [7:0]  a8, b8;
   logic [8:0]  z8;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   pipelined_addsub #(.WIDTH(16), .CHUNK(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16), .sub(s16),
      .a(a16), .b(b16), .out_valid(ov16), .out_ready(r16), .z(z16), .ovf(of16)
   );

   pipelined_addsub #(.WIDTH(8), .CHUNK(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .sub(s8),
      .a(a8), .b(b8), .out_valid(ov8), .out_ready(r8), .z(z8), .ovf(of8)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: arithmetic on integers, z = (a +/- b) mod 2^(w+1) with
   // subtraction as a + 2^w - b; overflow from the signed-range test.
   function automatic void ref_op(input int w, input logic s, input longint av,
                                  input longint bv, output longint ez, output logic eo);
      longint m, full, sa, sb, r;
      m    = longint'(1) << w;
      full = s ? (av + m - bv) : (av + bv);
      ez   = full % (2 * m);
      sa   = (av >= m / 2) ? av - m : av;
      sb   = (bv >= m / 2) ? bv - m : bv;
      r    = s ? (sa - sb) : (sa + sb);
      eo   = (r < -(m / 2)) || (r >= (m / 2));
   endfunction

   // One isolated operation: checks acceptance, latency, result and a one-cycle output pulse.
   task automatic op(input bit u8, input logic s, input longint av, input longint bv,
                     input longint ez, input logic eo, input int elat, input string tag);
      int   lat;
      logic seen;
      lat  = 0;
      seen = 1'b0;
      @(negedge clk);
      if (u8) begin v8 = 1'b1; s8 = s; a8 = av[7:0];  b8 = bv[7:0];  r8 = 1'b1; end
      else    begin v16 = 1'b1; s16 = s; a16 = av[15:0]; b16 = bv[15:0]; r16 = 1'b1; end
      #1;
      chk({tag, ".in_ready"}, u8 ? ir8 : ir16, 1);
      @(posedge clk);
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(negedge clk);
         v8  = 1'b0;
         v16 = 1'b0;
         if (u8 ? ov8 : ov16) begin
            seen = 1'b1;
            lat  = i;
         end else begin
            @(posedge clk);
         end
      end
      chk({tag, ".latency"}, lat, elat);
      chk({tag, ".z"}, u8 ? 64'(z8) : 64'(z16), ez);
      chk({tag, ".ovf"}, u8 ? of8 : of16, eo);
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".pulse"}, u8 ? ov8 : ov16, 0);
   endtask

   logic [15:0] ta [10];
   logic [15:0] tb [10];
   logic        ts [10];
   longint      exq [$];
   logic        eoq [$];

   initial begin
      longint ez;
      logic   eo;
      int     nin, nout, cyc;
      logic   saw_full, stalled;
      logic [16:0] hz;
      logic   ho;

      rst_n = 1'b0;
      v16 = 1'b0; s16 = 1'b0; a16 = '0; b16 = '0; r16 = 1'b1;
      v8  = 1'b0; s8  = 1'b0; a8  = '0; b8  = '0; r8  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.out_valid", ov16, 0);
      chk("rst.z", z16, 0);
      chk("rst.ovf", of16, 0);
      chk("rst.in_ready", ir16, 1);
      chk("rst8.out_valid", ov8, 0);
      rst_n = 1'b1;

      // Directed cases on the 4-stage unit
      op(0, 1'b0, 'h1234, 'h0FFF, 'h02233, 1'b0, 4, "add1");
      op(0, 1'b1, 'h0005, 'h0007, 'h0FFFE, 1'b0, 4, "sub_borrow");
      op(0, 1'b1, 'h8000, 'h0001, 'h17FFF, 1'b1, 4, "sub_ovf");
      op(0, 1'b0, 'h7FFF, 'h0001, 'h08000, 1'b1, 4, "add_ovf");
      op(0, 1'b0, 'hFFFF, 'h0001, 'h10000, 1'b0, 4, "add_ripple");

      for (int i = 0; i < 4; i++) begin
         longint ra, rb;
         logic   rs;
         ra = longint'($urandom_range(0, 65535));
         rb = longint'($urandom_range(0, 65535));
         rs = 1'($urandom_range(0, 1));
         ref_op(16, rs, ra, rb, ez, eo);
         op(0, rs, ra, rb, ez, eo, 4, "rand16");
      end

      // Back-to-back stream with the consumer stalled for three cycles
      for (int i = 0; i < 10; i++) begin
         ta[i] = 16'($urandom);
         tb[i] = 16'($urandom);
         ts[i] = 1'($urandom_range(0, 1));
      end
      nin = 0; nout = 0; cyc = 0;
      saw_full = 1'b0; stalled = 1'b0; hz = '0; ho = 1'b0;
      while (nout < 10 && cyc < 80) begin
         @(negedge clk);
         r16 = !(cyc >= 6 && cyc <= 8);
         if (nin < 10) begin
            v16 = 1'b1; a16 = ta[nin]; b16 = tb[nin]; s16 = ts[nin];
         end else begin
            v16 = 1'b0;
         end
         #1;
         chk("stream.in_ready", ir16, (exq.size() < 4) || r16);
         if (!ir16) saw_full = 1'b1;
         if (ov16 && !r16) begin
            if (stalled) begin
               chk("stream.hold_z", z16, hz);
               chk("stream.hold_ovf", of16, ho);
            end
            hz = z16; ho = of16; stalled = 1'b1;
         end else begin
            stalled = 1'b0;
         end
         if (nout > 0 && r16 && exq.size() > 0) chk("stream.no_gap", ov16, 1);
         if (ov16 && r16) begin
            if (exq.size() == 0) begin
               chk("stream.spurious", ov16, 0);
            end else begin
               chk("stream.z", z16, exq.pop_front());
               chk("stream.ovf", of16, eoq.pop_front());
            end
            nout++;
         end
         if (v16 && ir16) begin
            ref_op(16, ts[nin], longint'(ta[nin]), longint'(tb[nin]), ez, eo);
            exq.push_back(ez);
            eoq.push_back(eo);
            nin++;
         end
         @(posedge clk);
         cyc++;
      end
      chk("stream.count", nout, 10);
      chk("stream.saw_full", saw_full, 1);
      @(negedge clk);
      v16 = 1'b0; r16 = 1'b1;

      // Reset with three beats in flight
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         v16 = 1'b1; s16 = 1'b0; a16 = 16'(i + 1); b16 = 16'h0100;
      end
      @(negedge clk);
      v16 = 1'b0; rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("flush.out_valid", ov16, 0);
      chk("flush.z", z16, 0);
      chk("flush.ovf", of16, 0);
      chk("flush.in_ready", ir16, 1);
      rst_n = 1'b1;
      op(0, 1'b0, 'h0001, 'h0001, 'h00002, 1'b0, 4, "after_flush");

      // Single-stage unit
      op(1, 1'b0, 'hFF, 'h01, 'h100, 1'b0, 1, "w8_add");
      op(1, 1'b1, 'h80, 'h01, 'h17F, 1'b1, 1, "w8_sub");
      for (int i = 0; i < 4; i++) begin
         longint ra, rb;
         logic   rs;
         ra = longint'($urandom_range(0, 255));
         rb = longint'($urandom_range(0, 255));
         rs = 1'($urandom_range(0, 1));
         ref_op(8, rs, ra, rb, ez, eo);
         op(1, rs, ra, rb, ez, eo, 1, "rand8");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
